// File: rtl/div_nonrestoring_seq.sv
// div_nonrestoring_seq: sequential radix-2 non-restoring divider.
// One quotient bit per clock, start/done handshake, divide-by-zero flag.
// Optional signed operation is enabled by defining DIV_SIGNED_EN; the
// default build treats both operands as unsigned.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_start; operands captured on accept
// CALC  | WIDTH iterations, one shift/add-or-subtract per cycle
// FIX   | final remainder restore and sign correction, results loaded
// DONE  | o_done pulse; results visible; returns to IDLE
module div_nonrestoring_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_dz,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             div_zero;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   a_fixed;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

`ifdef DIV_SIGNED_EN
  logic sq_reg;
  logic sr_reg;

  // Magnitudes of the signed operands; the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    dvd_mag = i_dividend[WIDTH-1] ? ({WIDTH{1'b0}} - i_dividend) : i_dividend;
    dvs_mag = i_divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - i_divisor)  : i_divisor;
  end
`else
  // Unsigned operands are their own magnitudes.
  always_comb begin
    dvd_mag = i_dividend;
    dvs_mag = i_divisor;
  end
`endif

  assign div_zero = (i_divisor == {WIDTH{1'b0}});

  // One non-restoring iteration plus the final restore step.
  always_comb begin
    m_ext   = {1'b0, m_reg};
    a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    if (a_reg[WIDTH])
      a_next = a_shift + m_ext;
    else
      a_next = a_shift + (~m_ext + {{WIDTH{1'b0}}, 1'b1});
    q_next  = {q_reg[WIDTH-2:0], ~a_next[WIDTH]};
    a_fixed = a_reg[WIDTH] ? (a_reg + m_ext) : a_reg;
`ifdef DIV_SIGNED_EN
    q_final = sq_reg ? ({WIDTH{1'b0}} - q_reg) : q_reg;
    r_final = sr_reg ? ({WIDTH{1'b0}} - a_fixed[WIDTH-1:0]) : a_fixed[WIDTH-1:0];
`else
    q_final = q_reg;
    r_final = a_fixed[WIDTH-1:0];
`endif
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; a zero divisor skips straight to DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (i_start) state_nxt = div_zero ? S_DONE : S_CALC;
      S_CALC: if (cnt == CW'(1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    o_busy = (state != S_IDLE);
    o_done = (state == S_DONE);
  end

  // Datapath and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      cnt         <= '0;
      o_dz        <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
`ifdef DIV_SIGNED_EN
      sq_reg      <= 1'b0;
      sr_reg      <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            a_reg <= '0;
            q_reg <= dvd_mag;
            m_reg <= dvs_mag;
            cnt   <= CW'(WIDTH);
            o_dz  <= div_zero;
`ifdef DIV_SIGNED_EN
            sq_reg <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            sr_reg <= i_dividend[WIDTH-1];
`endif
            if (div_zero) begin
              o_quotient  <= {WIDTH{1'b1}};
              o_remainder <= i_dividend;
            end
          end
        end
        S_CALC: begin
          a_reg <= a_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          a_reg       <= a_fixed;
          o_quotient  <= q_final;
          o_remainder <= r_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nonrestoring_seq.sv
// Directed bench for div_nonrestoring_seq (WIDTH=32): vector table plus
// hand-written sequences for busy-start, done-cycle start and mid-op reset.
module tb_div_nonrestoring_seq;

  localparam int W     = 32;
  localparam int LAT   = W + 2;
  localparam int LIMIT = 100;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic         o_busy;
  logic         o_done;
  logic         o_dz;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  div_nonrestoring_seq #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_dz        (o_dz),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                              input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz);
    vec_t v;
    v.dvd = dvd; v.dvs = dvs; v.q = q; v.r = r; v.dz = dz;
    v.lat = dz ? 1 : LAT;
    return v;
  endfunction

  // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle.
  task automatic run_op(input vec_t v, input string tag);
    int n;
    int busy_n;
    bit seen;
    i_dividend = v.dvd;
    i_divisor  = v.dvs;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start    = 1'b0;
    i_dividend = $urandom;
    i_divisor  = $urandom;
    n = 1; busy_n = 0; seen = 1'b0;
    while (n <= LIMIT) begin
      if (o_busy) busy_n++;
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge i_clk);
      n++;
    end
    if (!seen) begin
      errors++; checks++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, LIMIT);
    end else begin
      chk({tag, " latency"}, 64'(n), 64'(v.lat));
      chk({tag, " busy_cycles"}, 64'(busy_n), 64'(v.lat));
      chk({tag, " quotient"}, 64'(o_quotient), 64'(v.q));
      chk({tag, " remainder"}, 64'(o_remainder), 64'(v.r));
      chk({tag, " dz"}, 64'(o_dz), 64'(v.dz));
      @(negedge i_clk);
      chk({tag, " done_pulse"}, 64'(o_done), 64'd0);
      chk({tag, " idle_after"}, 64'(o_busy), 64'd0);
    end
  endtask

  initial begin
    int first_done;
    int done_cnt;
    logic [W-1:0] cap_q;
    logic [W-1:0] cap_r;

`ifdef DIV_SIGNED_EN
    vecs.push_back(mk(32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0));
    vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0));
    vecs.push_back(mk(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(32'd100,       32'd7,         32'd14,        32'd2,        1'b0));
    vecs.push_back(mk(32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1));
    vecs.push_back(mk(32'd9,         32'd3,         32'd3,         32'd0,        1'b0));
`else
    vecs.push_back(mk(32'd100,       32'd7,         32'd14,        32'd2,        1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,        1'b0));
    vecs.push_back(mk(32'h0000_000A, 32'hFFFF_FFFF, 32'd0,         32'hA,        1'b0));
    vecs.push_back(mk(32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,        1'b1));
    vecs.push_back(mk(32'd9,         32'd3,         32'd3,         32'd0,        1'b0));
    vecs.push_back(mk(32'd0,         32'd5,         32'd0,         32'd0,        1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,        1'b0));
    vecs.push_back(mk(32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'd2,        1'b0));
    vecs.push_back(mk(32'd12345678,  32'd1000,      32'd12345,     32'd678,      1'b0));
`endif

    i_rst = 1'b1; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    repeat (3) @(negedge i_clk);
    chk("reset busy", 64'(o_busy), 64'd0);
    chk("reset done", 64'(o_done), 64'd0);
    chk("reset dz", 64'(o_dz), 64'd0);
    chk("reset quotient", 64'(o_quotient), 64'd0);
    chk("reset remainder", 64'(o_remainder), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed while busy must be ignored; exactly one done pulse.
    i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    first_done = 0; done_cnt = 0; cap_q = '0; cap_r = '0;
    for (int n = 1; n <= LAT + 12; n++) begin
      if (n == 10) begin
        i_start = 1'b1; i_dividend = 32'd50; i_divisor = 32'd5;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = n; cap_q = o_quotient; cap_r = o_remainder;
        end
      end
      @(negedge i_clk);
    end
    i_start = 1'b0;
    chk("busy_start done_count", 64'(done_cnt), 64'd1);
    chk("busy_start latency", 64'(first_done), 64'(LAT));
    chk("busy_start quotient", 64'(cap_q), 64'd14);
    chk("busy_start remainder", 64'(cap_r), 64'd2);

    // Start raised in the done cycle is ignored.
    i_dividend = 32'd9; i_divisor = 32'd0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("dz_seq done", 64'(o_done), 64'd1);
    i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("done_cycle_start busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    chk("done_cycle_start still_idle", 64'(o_busy), 64'd0);
    chk("done_cycle_start dz_held", 64'(o_dz), 64'd1);

    // Reset mid-operation abandons the op and clears all outputs.
    i_dividend = 32'd100; i_divisor = 32'd7; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (14) @(negedge i_clk);
    chk("midop busy_before_reset", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midop reset busy", 64'(o_busy), 64'd0);
    chk("midop reset done", 64'(o_done), 64'd0);
    chk("midop reset dz", 64'(o_dz), 64'd0);
    chk("midop reset quotient", 64'(o_quotient), 64'd0);
    chk("midop reset remainder", 64'(o_remainder), 64'd0);
    run_op(mk(32'd20, 32'd6, 32'd3, 32'd2, 1'b0), "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_nonrestoring_seq.md
Name: div_nonrestoring_seq

Overview:
- Sequential radix-2 non-restoring divider; the inverse operation of the Booth multiplier control path.
- Serves the mantissa divide path of the parametrizable FPU, alongside the Booth multiplier.
- Iterates one quotient bit per clock, using the shared two's-complement and add/subtract datapath style.
- Uses a start/done handshake with a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (equals SIZE/2 of the multiplier path); must be >= 2.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_start  input  1  request; sampled only in IDLE.
- i_dividend  input  WIDTH  dividend; captured on the accepted start.
- i_divisor  input  WIDTH  divisor; captured on the accepted start.
- o_busy  output  1  high from the cycle after accept until the cycle o_done is high, inclusive.
- o_done  output  1  single-cycle pulse; results valid.
- o_dz  output  1  divide-by-zero flag, valid with o_done, held until the next accept.
- o_quotient  output  WIDTH  quotient, held until the next accept.
- o_remainder  output  WIDTH  remainder, held until the next accept.

Behaviour:
- Reset (i_rst=1 at an edge):
  - State returns to IDLE; counter clears.
  - o_busy=0, o_done=0, o_dz=0, o_quotient=0, o_remainder=0.
  - Any operation in flight is abandoned.
  - Reset has priority over i_start.
- State machine: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - i_start=1 accepts the operands.
  - Registers: A (WIDTH+1 bits, signed partial remainder) = 0; Q = dividend magnitude; M = divisor magnitude; counter = WIDTH.
  - Divisor == 0: go to DONE directly.
  - Otherwise: go to CALC.
- CALC, one iteration per cycle:
  - Shift {A,Q} left 1.
  - If the old A was >= 0, A = A - M; else A = A + M.
  - Subtraction is via the two's complement of M; M is zero-extended to WIDTH+1.
  - Q[0] = ~A_new[WIDTH].
  - Counter decrements; counter reaching 0 moves to FIX. CALC lasts exactly WIDTH cycles.
- FIX (one cycle):
  - If A < 0, A = A + M.
  - Then apply the sign correction (see Optional Feature).
  - Go to DONE.
- DONE (one cycle):
  - o_done=1 and outputs are updated.
  - Return to IDLE.
- Latency:
  - Start accepted at edge 0 gives o_done high in the cycle after edge WIDTH+2 (34 cycles for WIDTH=32).
  - Divide-by-zero gives o_done after edge 1.
- Divide-by-zero result: o_dz=1, o_quotient = all ones, o_remainder = i_dividend as captured.
- Handshake rules:
  - i_start is ignored while o_busy=1; there is no queueing and captured operands are unaffected.
  - i_start=1 in the same cycle as o_done is ignored (the FSM is not yet in IDLE).
  - Back-to-back throughput is one op per WIDTH+3 cycles.
- Input operands are not required to stay stable after accept.
- Invariant (unsigned, divisor != 0): dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's-complement signed.
  - At accept, take magnitudes and record sq = sign(dividend) XOR sign(divisor) and sr = sign(dividend).
  - In FIX, negate the quotient if sq and negate the remainder if sr.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Most-negative / -1 gives quotient = most-negative and remainder 0 (wraps, no flag).
  - Divide-by-zero: quotient all ones, remainder = dividend.
- Undefined: operands are unsigned; no sign logic is synthesized.

Test Plan:
- Unsigned basic, WIDTH=32: start with 100/7 -> o_done after edge 34, quotient=14, remainder=2, o_dz=0; o_busy high for 34 cycles.
- Unsigned max: 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; then 0x0000000A / 0xFFFFFFFF -> quotient 0, remainder 0xA.
- Divide-by-zero: 5/0 -> o_done after edge 1, o_dz=1, quotient 0xFFFFFFFF, remainder 5; the next op 9/3 clears o_dz, giving quotient 3, remainder 0.
- Start while busy: start 100/7, then pulse i_start with 50/5 at cycle 10 -> ignored; result is 14 r2 and only one o_done pulse.
- Reset mid-op: assert i_rst at cycle 15 of 100/7 -> next cycle all outputs 0 and state IDLE; a fresh start 20/6 gives 3 r2 with full latency.
- DIV_SIGNED_EN:
  - -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
  - 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
